// File: rtl/uart_mode_ctrl_pkg.sv
// Shared constants for the UART mode controller: baud encodings, baud rates,
// FSM state encodings and the debounced-switch reset pattern.
package uart_mode_ctrl_pkg;

    localparam logic [1:0] BAUD_SEL_9600   = 2'b00;
    localparam logic [1:0] BAUD_SEL_57600  = 2'b01;
    localparam logic [1:0] BAUD_SEL_115200 = 2'b10;
    localparam logic [1:0] BAUD_SEL_230400 = 2'b11;

    localparam int BAUD_RATE_9600   = 32'd9600;
    localparam int BAUD_RATE_57600  = 32'd57600;
    localparam int BAUD_RATE_115200 = 32'd115200;
    localparam int BAUD_RATE_230400 = 32'd230400;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PEND   = 2'd1;
    localparam logic [1:0] ST_APPLY  = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    // Debounced switches come out of reset as mode=0, baud select=01.
    localparam logic [2:0] SW_RESET_VAL = 3'b010;

endpackage

// File: rtl/uart_mode_ctrl_sw.sv
// Single-switch debouncer: 2-flop synchronizer followed by a stability counter.
module sw_debounce #(
    parameter int   DEBOUNCE_MAX = 50_000,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic src_clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_db
);

    localparam int CNT_W = (DEBOUNCE_MAX > 1) ? $clog2(DEBOUNCE_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             db_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize the raw switch and accept it once stable for DEBOUNCE_MAX cycles.
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= RESET_VAL;
            sync2_r <= RESET_VAL;
            db_r    <= RESET_VAL;
            cnt_r   <= '0;
        end else begin
            sync1_r <= sw_raw;
            sync2_r <= sync1_r;
            if (sync2_r == db_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                db_r  <= sync2_r;
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign sw_db = db_r;

endmodule

// File: rtl/uart_mode_ctrl.sv
// UART configuration controller: debounces the mode switches and applies
// baud/direction changes only between frames, followed by a settle window.
module uart_mode_ctrl
    import uart_mode_ctrl_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int DIV_W         = 16,
    parameter int DEBOUNCE_MAX  = 50_000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             src_clk,
    input  logic             rst_n,
    input  logic [2:0]       switches,
    input  logic             tx_busy,
    input  logic             rx_busy,
    output logic [1:0]       baud_sel,
    output logic [DIV_W-1:0] baud_div,
    output logic             data_dir,
    output logic             mode_locked,
    output logic             uart_hold,
    output logic             cfg_update
);

    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(CLK_HZ / BAUD_RATE_9600);
    localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(CLK_HZ / BAUD_RATE_57600);
    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(CLK_HZ / BAUD_RATE_115200);
    localparam logic [DIV_W-1:0] DIV_230400 = DIV_W'(CLK_HZ / BAUD_RATE_230400);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

    logic [2:0]       sw_db_s;
    logic [1:0]       tgt_baud_s;
    logic             tgt_dir_s;
    logic [DIV_W-1:0] tgt_div_s;
    logic             cfg_diff_s;

    logic [1:0]       state_r;
    logic [SC_W-1:0]  settle_cnt_r;
    logic [1:0]       baud_sel_r;
    logic [DIV_W-1:0] baud_div_r;
    logic             data_dir_r;
    logic             uart_hold_r;
    logic             cfg_update_r;

    for (genvar i = 0; i < 3; i++) begin : g_db
        sw_debounce #(
            .DEBOUNCE_MAX (DEBOUNCE_MAX),
            .RESET_VAL    (SW_RESET_VAL[i])
        ) u_sw_debounce (
            .src_clk (src_clk),
            .rst_n   (rst_n),
            .sw_raw  (switches[i]),
            .sw_db   (sw_db_s[i])
        );
    end

    // Locked mode freezes the baud and lets SW1 steer direction; unlocked is the reverse.
    always_comb begin
        tgt_baud_s = baud_sel_r;
        tgt_dir_s  = data_dir_r;
        if (sw_db_s[0]) begin
            tgt_baud_s = baud_sel_r;
            tgt_dir_s  = sw_db_s[1];
        end else begin
            tgt_baud_s = sw_db_s[2:1];
            tgt_dir_s  = data_dir_r;
        end
        cfg_diff_s = (tgt_baud_s != baud_sel_r) || (tgt_dir_s != data_dir_r);
    end

    // Divisor lookup for the target baud select.
    always_comb begin
        tgt_div_s = DIV_57600;
        case (tgt_baud_s)
            BAUD_SEL_9600:   tgt_div_s = DIV_9600;
            BAUD_SEL_57600:  tgt_div_s = DIV_57600;
            BAUD_SEL_115200: tgt_div_s = DIV_115200;
            BAUD_SEL_230400: tgt_div_s = DIV_230400;
            default:         tgt_div_s = DIV_57600;
        endcase
    end

    // Change-sequencing FSM: stall frames, wait for idle UART, apply, settle.
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= '0;
            baud_sel_r   <= BAUD_SEL_57600;
            baud_div_r   <= DIV_57600;
            data_dir_r   <= 1'b0;
            uart_hold_r  <= 1'b0;
            cfg_update_r <= 1'b0;
        end else begin
            cfg_update_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_diff_s) begin
                        state_r     <= ST_PEND;
                        uart_hold_r <= 1'b1;
                    end else begin
                        uart_hold_r <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (!cfg_diff_s) begin
                        state_r     <= ST_IDLE;
                        uart_hold_r <= 1'b0;
                    end else if (!tx_busy && !rx_busy) begin
                        state_r <= ST_APPLY;
                    end else begin
                        state_r <= ST_PEND;
                    end
                end
                ST_APPLY: begin
                    baud_sel_r   <= tgt_baud_s;
                    baud_div_r   <= tgt_div_s;
                    data_dir_r   <= tgt_dir_s;
                    cfg_update_r <= 1'b1;
                    settle_cnt_r <= SETTLE_LOAD;
                    state_r      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == '0) begin
                        state_r     <= ST_IDLE;
                        uart_hold_r <= 1'b0;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - SC_W'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    uart_hold_r <= 1'b0;
                end
            endcase
        end
    end

    assign baud_sel    = baud_sel_r;
    assign baud_div    = baud_div_r;
    assign data_dir    = data_dir_r;
    assign mode_locked = sw_db_s[0];
    assign uart_hold   = uart_hold_r;
    assign cfg_update  = cfg_update_r;

endmodule

// File: tb/tb_uart_mode_ctrl.sv
// Self-checking bench for uart_mode_ctrl: directed scenarios plus randomized
// switch/busy traffic compared against a behavioural configuration model.
module tb_uart_mode_ctrl;

    localparam int CLK_HZ  = 50_000_000;
    localparam int DIV_W   = 16;
    localparam int DB_MAX  = 4;
    localparam int SETTLE  = 8;
    localparam int DB_LAT  = 2 + DB_MAX;
    localparam logic [DIV_W-1:0] RESET_DIV = 16'd868;

    logic             src_clk;
    logic             rst_n;
    logic [2:0]       switches;
    logic             tx_busy;
    logic             rx_busy;
    logic [1:0]       baud_sel;
    logic [DIV_W-1:0] baud_div;
    logic             data_dir;
    logic             mode_locked;
    logic             uart_hold;
    logic             cfg_update;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic prev_pulse = 1'b0;

    // Reference model state: applied configuration and expected update count.
    logic [1:0] m_baud;
    logic       m_dir;
    int         m_pulses = 0;
    int         rates [4] = '{9600, 57600, 115200, 230400};

    uart_mode_ctrl #(
        .CLK_HZ        (CLK_HZ),
        .DIV_W         (DIV_W),
        .DEBOUNCE_MAX  (DB_MAX),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .src_clk     (src_clk),
        .rst_n       (rst_n),
        .switches    (switches),
        .tx_busy     (tx_busy),
        .rx_busy     (rx_busy),
        .baud_sel    (baud_sel),
        .baud_div    (baud_div),
        .data_dir    (data_dir),
        .mode_locked (mode_locked),
        .uart_hold   (uart_hold),
        .cfg_update  (cfg_update)
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Count update pulses and flag any that last longer than one cycle.
    always @(negedge src_clk) begin
        if (cfg_update === 1'b1) begin
            pulse_cnt++;
            checks++;
            if (prev_pulse === 1'b1) begin
                errors++;
                $display("FAIL pulse_width: cfg_update high on consecutive cycles, required single-cycle");
            end
        end
        prev_pulse = cfg_update;
    end

    function automatic int exp_div(input logic [1:0] sel);
        return CLK_HZ / rates[sel];
    endfunction

    function void model_reset();
        m_baud = 2'b01;
        m_dir  = 1'b0;
    endfunction

    // Final configuration once the given switch setting is stable and the UART is idle.
    function void model_apply(input logic [2:0] sw);
        logic [1:0] nb;
        logic       nd;
        if (sw[0]) begin
            nb = m_baud;
            nd = sw[1];
        end else begin
            nb = sw[2:1];
            nd = m_dir;
        end
        if (nb != m_baud || nd != m_dir) m_pulses++;
        m_baud = nb;
        m_dir  = nd;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge src_clk);
    endtask

    task automatic measure(input logic [2:0] sw, output int hold_rise,
                           output int pulse_at, output int hold_after);
        hold_rise  = -1;
        pulse_at   = -1;
        hold_after = 0;
        switches   = sw;
        for (int k = 1; k <= 30; k++) begin
            @(negedge src_clk);
            if (uart_hold === 1'b1 && hold_rise < 0) hold_rise = k;
            if (cfg_update === 1'b1 && pulse_at < 0) pulse_at = k;
            if (pulse_at >= 0 && uart_hold === 1'b1) hold_after++;
        end
    endtask

    task automatic test_reset();
        int p0;
        rst_n = 1'b0; switches = 3'b010; tx_busy = 1'b0; rx_busy = 1'b0;
        model_reset();
        tick(3);
        checks++;
        if ({baud_sel, baud_div} !== {2'b01, RESET_DIV}) begin
            errors++; $display("FAIL reset_baud: got %b/%0d required 01/%0d", baud_sel, baud_div, RESET_DIV);
        end
        checks++;
        if ({data_dir, mode_locked, uart_hold, cfg_update} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got dir/lock/hold/upd=%b%b%b%b required 0000",
                               data_dir, mode_locked, uart_hold, cfg_update);
        end
        rst_n = 1'b1;
        p0 = pulse_cnt;
        tick(15);
        checks++;
        if (pulse_cnt != p0 || uart_hold !== 1'b0) begin
            errors++; $display("FAIL reset_quiet: pulses %0d hold %b required 0/0", pulse_cnt - p0, uart_hold);
        end
    endtask

    task automatic test_baud_sweep();
        logic [2:0] seq [3] = '{3'b100, 3'b000, 3'b110};
        int hr, pa, ha, p0;
        foreach (seq[i]) begin
            p0 = pulse_cnt;
            model_apply(seq[i]);
            measure(seq[i], hr, pa, ha);
            checks++;
            if (hr != DB_LAT + 1 || pa != DB_LAT + 3) begin
                errors++; $display("FAIL sweep_timing[%0d]: hold at %0d pulse at %0d required %0d/%0d",
                                   i, hr, pa, DB_LAT + 1, DB_LAT + 3);
            end
            checks++;
            if (ha != SETTLE) begin
                errors++; $display("FAIL sweep_settle[%0d]: hold cycles %0d required %0d", i, ha, SETTLE);
            end
            checks++;
            if ({baud_sel, baud_div, data_dir} !== {m_baud, DIV_W'(exp_div(m_baud)), m_dir}) begin
                errors++; $display("FAIL sweep_cfg[%0d]: got %b/%0d/%b required %b/%0d/%b", i,
                                   baud_sel, baud_div, data_dir, m_baud, exp_div(m_baud), m_dir);
            end
            checks++;
            if (pulse_cnt - p0 != 1 || uart_hold !== 1'b0) begin
                errors++; $display("FAIL sweep_pulse[%0d]: pulses %0d hold %b required 1/0",
                                   i, pulse_cnt - p0, uart_hold);
            end
        end
    endtask

    task automatic test_busy();
        logic [1:0] old_baud;
        int p0, seen;
        old_baud = m_baud;
        p0 = pulse_cnt;
        tx_busy = 1'b1;
        switches = 3'b000;
        model_apply(3'b000);
        tick(25);
        checks++;
        if (uart_hold !== 1'b1 || baud_sel !== old_baud || pulse_cnt != p0) begin
            errors++; $display("FAIL busy_stall: hold %b baud %b pulses %0d required 1/%b/0",
                               uart_hold, baud_sel, pulse_cnt - p0, old_baud);
        end
        tx_busy = 1'b0;
        seen = -1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge src_clk);
            if (cfg_update === 1'b1 && seen < 0) seen = k;
        end
        checks++;
        if (seen != 2) begin
            errors++; $display("FAIL busy_release: pulse at %0d required 2", seen);
        end
        tick(15);
        checks++;
        if ({baud_sel, baud_div, uart_hold} !== {m_baud, DIV_W'(exp_div(m_baud)), 1'b0}) begin
            errors++; $display("FAIL busy_cfg: got %b/%0d hold %b required %b/%0d/0",
                               baud_sel, baud_div, uart_hold, m_baud, exp_div(m_baud));
        end
    endtask

    task automatic test_locked();
        logic [2:0] seq [4] = '{3'b001, 3'b011, 3'b101, 3'b111};
        int p0, mp0;
        switches = 3'b010;
        model_apply(3'b010);
        tick(30);
        p0 = pulse_cnt;
        mp0 = m_pulses;
        foreach (seq[i]) begin
            switches = seq[i];
            model_apply(seq[i]);
            tick(30);
            checks++;
            if (data_dir !== m_dir || mode_locked !== 1'b1) begin
                errors++; $display("FAIL locked_dir[%0d]: dir %b lock %b required %b/1",
                                   i, data_dir, mode_locked, m_dir);
            end
        end
        checks++;
        if (baud_sel !== 2'b01 || pulse_cnt - p0 != m_pulses - mp0) begin
            errors++; $display("FAIL locked_baud: baud %b pulses %0d required 01/%0d",
                               baud_sel, pulse_cnt - p0, m_pulses - mp0);
        end
    endtask

    task automatic test_glitch();
        int p0;
        logic hold_seen;
        switches = 3'b010;
        model_apply(3'b010);
        tick(30);
        p0 = pulse_cnt;
        hold_seen = 1'b0;
        switches = 3'b110;
        tick(2);
        switches = 3'b010;
        for (int k = 0; k < 30; k++) begin
            @(negedge src_clk);
            if (uart_hold === 1'b1) hold_seen = 1'b1;
        end
        checks++;
        if (hold_seen || pulse_cnt != p0 || baud_sel !== m_baud) begin
            errors++; $display("FAIL glitch: hold_seen %b pulses %0d baud %b required 0/0/%b",
                               hold_seen, pulse_cnt - p0, baud_sel, m_baud);
        end
    endtask

    task automatic test_revert();
        int p0, waited;
        p0 = pulse_cnt;
        rx_busy = 1'b1;
        switches = 3'b100;
        waited = 0;
        while (uart_hold !== 1'b1 && waited < 20) begin
            @(negedge src_clk);
            waited++;
        end
        checks++;
        if (uart_hold !== 1'b1) begin
            errors++; $display("FAIL revert_pend: hold %b required 1 within 20 cycles", uart_hold);
        end
        switches = 3'b010;
        tick(20);
        checks++;
        if (uart_hold !== 1'b0 || pulse_cnt != p0 || baud_sel !== m_baud) begin
            errors++; $display("FAIL revert_idle: hold %b pulses %0d baud %b required 0/0/%b",
                               uart_hold, pulse_cnt - p0, baud_sel, m_baud);
        end
        rx_busy = 1'b0;
        tick(5);
        checks++;
        if (pulse_cnt != p0) begin
            errors++; $display("FAIL revert_late: pulses %0d required 0", pulse_cnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        int p0, waited;
        p0 = pulse_cnt;
        switches = 3'b100;
        model_apply(3'b100);
        waited = 0;
        while (cfg_update !== 1'b1 && waited < 30) begin
            @(negedge src_clk);
            waited++;
        end
        switches = 3'b110;
        model_apply(3'b110);
        tick(45);
        checks++;
        if (pulse_cnt - p0 != 2 || {baud_sel, baud_div} !== {m_baud, DIV_W'(exp_div(m_baud))}) begin
            errors++; $display("FAIL back_to_back: pulses %0d baud %b/%0d required 2/%b/%0d",
                               pulse_cnt - p0, baud_sel, baud_div, m_baud, exp_div(m_baud));
        end
    endtask

    task automatic test_reset_mid_settle();
        int waited, p0;
        switches = 3'b000;
        model_apply(3'b000);
        waited = 0;
        while (cfg_update !== 1'b1 && waited < 30) begin
            @(negedge src_clk);
            waited++;
        end
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({baud_sel, baud_div, data_dir, uart_hold, cfg_update} !== {2'b01, RESET_DIV, 3'b000}) begin
            errors++; $display("FAIL reset_async: got %b/%0d dir %b hold %b upd %b required 01/%0d/0/0/0",
                               baud_sel, baud_div, data_dir, uart_hold, cfg_update, RESET_DIV);
        end
        switches = 3'b010;
        tick(2);
        rst_n = 1'b1;
        model_reset();
        p0 = pulse_cnt;
        tick(20);
        checks++;
        if (pulse_cnt != p0 || baud_sel !== 2'b01 || uart_hold !== 1'b0) begin
            errors++; $display("FAIL reset_discard: pulses %0d baud %b hold %b required 0/01/0",
                               pulse_cnt - p0, baud_sel, uart_hold);
        end
    endtask

    task automatic test_random();
        logic [2:0] sw;
        int p0, mp0;
        for (int i = 0; i < 24; i++) begin
            sw = 3'($urandom_range(0, 7));
            p0 = pulse_cnt;
            mp0 = m_pulses;
            tx_busy = 1'($urandom_range(0, 1));
            rx_busy = 1'($urandom_range(0, 1));
            switches = sw;
            model_apply(sw);
            tick($urandom_range(0, 15));
            tx_busy = 1'b0;
            rx_busy = 1'b0;
            tick(30);
            checks++;
            if ({baud_sel, baud_div, data_dir, mode_locked} !==
                {m_baud, DIV_W'(exp_div(m_baud)), m_dir, sw[0]} || pulse_cnt - p0 != m_pulses - mp0) begin
                errors++; $display("FAIL random[%0d] sw=%b: got %b/%0d/%b/%b pulses %0d required %b/%0d/%b/%b pulses %0d",
                                   i, sw, baud_sel, baud_div, data_dir, mode_locked, pulse_cnt - p0,
                                   m_baud, exp_div(m_baud), m_dir, sw[0], m_pulses - mp0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_baud_sweep();
        test_busy();
        test_locked();
        test_glitch();
        test_revert();
        test_back_to_back();
        test_reset_mid_settle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
